// File: rtl/du_pkg.sv
// Shared definitions for the decode-unit issue scheduler: register file
// geometry, default pipeline-ID width and the issue FSM state encoding.
package du_pkg;

  localparam int REG_NUM   = 32;
  localparam int REG_AW    = 5;
  localparam int PID_W_DEF = 2;

  // Raw encodings kept as plain constants so older code can compare against them.
  localparam logic [1:0] ST_RUN    = 2'd0;
  localparam logic [1:0] ST_DRAIN  = 2'd1;
  localparam logic [1:0] ST_SERIAL = 2'd2;

  typedef enum logic [1:0] {
    RUN    = ST_RUN,
    DRAIN  = ST_DRAIN,
    SERIAL = ST_SERIAL
  } du_state_e;

endpackage

// File: rtl/du_issue_scheduler_if.sv
// Decode-pair / way-register handshake bundle between the decoder, the issue
// scheduler and the two decode->execute stage registers.
interface du_issue_scheduler_if
  import du_pkg::*;
#(
  parameter int PID_W = PID_W_DEF
);
  logic              dec0_valid;
  logic [REG_AW-1:0] dec0_rs1;
  logic [REG_AW-1:0] dec0_rs2;
  logic [REG_AW-1:0] dec0_rd;
  logic              dec0_rdwe;
  logic              dec0_mem;
  logic              dec0_serial;
  logic              dec1_valid;
  logic [REG_AW-1:0] dec1_rs1;
  logic [REG_AW-1:0] dec1_rs2;
  logic [REG_AW-1:0] dec1_rd;
  logic              dec1_rdwe;
  logic              dec1_mem;
  logic              dec1_serial;
  logic              way0_ready;
  logic              way1_ready;
  logic              way0_valid;
  logic              way1_valid;
  logic [PID_W-1:0]  way0_pid;
  logic [PID_W-1:0]  way1_pid;
  logic [1:0]        accept;

  // Decoder and stage-register side.
  modport master (
    output dec0_valid, dec0_rs1, dec0_rs2, dec0_rd, dec0_rdwe, dec0_mem, dec0_serial,
    output dec1_valid, dec1_rs1, dec1_rs2, dec1_rd, dec1_rdwe, dec1_mem, dec1_serial,
    output way0_ready, way1_ready,
    input  way0_valid, way1_valid, way0_pid, way1_pid, accept
  );

  // Scheduler side.
  modport slave (
    input  dec0_valid, dec0_rs1, dec0_rs2, dec0_rd, dec0_rdwe, dec0_mem, dec0_serial,
    input  dec1_valid, dec1_rs1, dec1_rs2, dec1_rd, dec1_rdwe, dec1_mem, dec1_serial,
    input  way0_ready, way1_ready,
    output way0_valid, way1_valid, way0_pid, way1_pid, accept
  );
endinterface

// File: rtl/du_scoreboard.sv
// 32-entry register busy scoreboard. Two set ports (issue), two clear ports
// (writeback), six combinational lookups that already see this cycle's clears.
// x0 is never busy; a set wins over a same-cycle clear of the same register.
module du_scoreboard
  import du_pkg::*;
(
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        flush,
  input  logic [1:0]                  set_en,
  input  logic [1:0][REG_AW-1:0]      set_addr,
  input  logic [1:0]                  clr_en,
  input  logic [1:0][REG_AW-1:0]      clr_addr,
  input  logic [5:0][REG_AW-1:0]      look_addr,
  output logic [5:0]                  look_busy
);

  logic [REG_NUM-1:0] busy_reg;
  logic [REG_NUM-1:0] busy_next;
  logic [REG_NUM-1:0] set_mask;
  logic [REG_NUM-1:0] clr_mask;
  logic [REG_NUM-1:0] busy_eff;

  genvar gi;
  generate
    for (gi = 0; gi < REG_NUM; gi++) begin : g_mask
      assign set_mask[gi] = (set_en[0] && set_addr[0] == REG_AW'(gi)) ||
                            (set_en[1] && set_addr[1] == REG_AW'(gi));
      assign clr_mask[gi] = (clr_en[0] && clr_addr[0] == REG_AW'(gi)) ||
                            (clr_en[1] && clr_addr[1] == REG_AW'(gi));
    end
    for (gi = 0; gi < 6; gi++) begin : g_look
      assign look_busy[gi] = busy_eff[look_addr[gi]];
    end
  endgenerate

  assign busy_eff = busy_reg & ~clr_mask;

  // Next busy vector: flush wipes everything, otherwise clears then sets; bit 0 pinned low.
  always_comb begin
    busy_next = '0;
    if (!flush) begin
      busy_next = {busy_eff[REG_NUM-1:1] | set_mask[REG_NUM-1:1], 1'b0};
    end
  end

  // Busy vector register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      busy_reg <= '0;
    end else begin
      busy_reg <= busy_next;
    end
  end

endmodule

// File: rtl/du_issue_scheduler.sv
// Dual-issue scheduler ahead of the way0/way1 decode->execute registers.
// Picks 0..2 instructions per cycle subject to register hazards, the in-flight
// limit, single-LSU and serialising rules, and stamps rolling pIDs.
// Optional: define DU_ISSUE_PERF_EN to add saturating stall/dual-issue counters.
module du_issue_scheduler
  import du_pkg::*;
#(
  parameter int PID_W        = PID_W_DEF,
  parameter int MAX_INFLIGHT = 4
)(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              flush_i,
  du_issue_scheduler_if.slave dif,
  input  logic              wb0_en_i,
  input  logic [REG_AW-1:0] wb0_addr_i,
  input  logic              wb1_en_i,
  input  logic [REG_AW-1:0] wb1_addr_i,
  input  logic [1:0]        retire_cnt_i,
  output logic [2:0]        inflight_o
`ifdef DU_ISSUE_PERF_EN
  ,
  output logic [31:0]       stall_cnt_o,
  output logic [31:0]       dual_cnt_o
`endif
);

  localparam logic [3:0] MAX_IF = 4'(MAX_INFLIGHT);

  logic [1:0]       state_reg, state_next;
  logic [2:0]       inflight_reg, inflight_next;
  logic [PID_W-1:0] pid_ctr_reg;
  logic [5:0]       look_busy;
  logic             haz0, haz1, dep1, cap0, cap1, base0;
  logic             issue0, issue1;
  logic [1:0]       issue_cnt;

  du_scoreboard u_sb (
    .clk       (clk),
    .reset_n   (reset_n),
    .flush     (flush_i),
    .set_en    ({issue1 & dif.dec1_rdwe, issue0 & dif.dec0_rdwe}),
    .set_addr  ({dif.dec1_rd, dif.dec0_rd}),
    .clr_en    ({wb1_en_i, wb0_en_i}),
    .clr_addr  ({wb1_addr_i, wb0_addr_i}),
    .look_addr ({dif.dec1_rd, dif.dec1_rs2, dif.dec1_rs1,
                 dif.dec0_rd, dif.dec0_rs2, dif.dec0_rs1}),
    .look_busy (look_busy)
  );

  assign haz0 = look_busy[0] | look_busy[1] | (dif.dec0_rdwe & look_busy[2]);
  assign haz1 = look_busy[3] | look_busy[4] | (dif.dec1_rdwe & look_busy[5]);
  assign cap0 = ({1'b0, inflight_reg} + 4'd1) <= MAX_IF;
  assign cap1 = ({1'b0, inflight_reg} + 4'd2) <= MAX_IF;
  // Intra-pair dependency on slot0's destination (RAW on rs1/rs2, WAW on rd).
  assign dep1 = dif.dec0_rdwe && (dif.dec0_rd != '0) &&
                ((dif.dec1_rs1 == dif.dec0_rd) || (dif.dec1_rs2 == dif.dec0_rd) ||
                 (dif.dec1_rd == dif.dec0_rd));
  assign base0 = !flush_i && dif.dec0_valid && dif.way0_ready && !haz0 && cap0;

  // Issue FSM: serialising slot0 waits for an empty pipe, runs alone, then drains again.
  always_comb begin
    issue0     = 1'b0;
    state_next = state_reg;
    case (state_reg)
      ST_RUN: begin
        if (dif.dec0_valid && dif.dec0_serial) begin
          if (inflight_reg == 3'd0) begin
            issue0 = base0;
            if (base0) state_next = ST_SERIAL;
          end else begin
            state_next = ST_DRAIN;
          end
        end else begin
          issue0 = base0;
        end
      end
      ST_DRAIN: begin
        if (inflight_reg == 3'd0 && base0) begin
          issue0     = 1'b1;
          state_next = ST_SERIAL;
        end
      end
      ST_SERIAL: begin
        if (inflight_reg == 3'd0) state_next = ST_RUN;
      end
      default: state_next = ST_RUN;
    endcase
    if (flush_i) state_next = ST_RUN;
  end

  assign issue1 = issue0 && (state_reg == ST_RUN) && !dif.dec0_serial && !dif.dec1_serial &&
                  dif.dec1_valid && dif.way1_ready && !haz1 && cap1 && !dep1 &&
                  !(dif.dec0_mem && dif.dec1_mem);

  assign issue_cnt      = {1'b0, issue0} + {1'b0, issue1};
  assign dif.accept     = issue_cnt;
  assign dif.way0_valid = issue0;
  assign dif.way1_valid = issue1;
  assign dif.way0_pid   = pid_ctr_reg;
  assign dif.way1_pid   = pid_ctr_reg + PID_W'(1);
  assign inflight_o     = inflight_reg;

  assign inflight_next = flush_i ? 3'd0 : inflight_reg + 3'(issue_cnt) - 3'(retire_cnt_i);

  // State, in-flight count and rolling pID; pID keeps counting across flushes.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg    <= ST_RUN;
      inflight_reg <= 3'd0;
      pid_ctr_reg  <= '0;
    end else begin
      state_reg    <= state_next;
      inflight_reg <= inflight_next;
      pid_ctr_reg  <= pid_ctr_reg + PID_W'(issue_cnt);
    end
  end

  a_retire_le_inflight: assert property (@(posedge clk) disable iff (!reset_n)
    flush_i || ({1'b0, retire_cnt_i} <= inflight_reg));

`ifdef DU_ISSUE_PERF_EN
  logic [31:0] stall_cnt_reg, dual_cnt_reg;

  // Saturating stall and dual-issue counters, cleared only by reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_cnt_reg <= '0;
      dual_cnt_reg  <= '0;
    end else begin
      if (dif.dec0_valid && !flush_i && issue_cnt == 2'd0 && stall_cnt_reg != '1)
        stall_cnt_reg <= stall_cnt_reg + 32'd1;
      if (issue_cnt == 2'd2 && dual_cnt_reg != '1)
        dual_cnt_reg <= dual_cnt_reg + 32'd1;
    end
  end

  assign stall_cnt_o = stall_cnt_reg;
  assign dual_cnt_o  = dual_cnt_reg;
`endif

endmodule

// File: tb/tb_du_issue_scheduler.sv
// Directed bench for du_issue_scheduler: dual issue, intra-pair dependency,
// in-flight limit, serialise/drain, flush and set-beats-clear scoreboard cases.
module tb_du_issue_scheduler;
  import du_pkg::*;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       flush_i = 1'b0;
  logic       wb0_en_i = 1'b0, wb1_en_i = 1'b0;
  logic [4:0] wb0_addr_i = '0, wb1_addr_i = '0;
  logic [1:0] retire_cnt_i = '0;
  logic [2:0] inflight_o;
  int         checks = 0;
  int         failures = 0;
  int         cyc_acc_exp = 0;
`ifdef DU_ISSUE_PERF_EN
  logic [31:0] stall_cnt_o, dual_cnt_o;
  int          exp_stall = 0;
  int          exp_dual = 0;
`endif

  du_issue_scheduler_if #(.PID_W(2)) dif ();

  du_issue_scheduler #(.PID_W(2), .MAX_INFLIGHT(4)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .flush_i      (flush_i),
    .dif          (dif.slave),
    .wb0_en_i     (wb0_en_i),
    .wb0_addr_i   (wb0_addr_i),
    .wb1_en_i     (wb1_en_i),
    .wb1_addr_i   (wb1_addr_i),
    .retire_cnt_i (retire_cnt_i),
    .inflight_o   (inflight_o)
`ifdef DU_ISSUE_PERF_EN
    ,
    .stall_cnt_o  (stall_cnt_o),
    .dual_cnt_o   (dual_cnt_o)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end else begin
      $display("ok   %s = %0d", tag, got);
    end
  endtask

  task automatic chk_acc(input string tag, input int e);
    cyc_acc_exp = e;
    chk(tag, 32'(dif.accept), 32'(e));
  endtask

  task automatic set0(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                      input logic [4:0] rd, input logic we, input logic mem, input logic ser);
    dif.dec0_valid = v; dif.dec0_rs1 = rs1; dif.dec0_rs2 = rs2; dif.dec0_rd = rd;
    dif.dec0_rdwe = we; dif.dec0_mem = mem; dif.dec0_serial = ser;
  endtask

  task automatic set1(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                      input logic [4:0] rd, input logic we, input logic mem, input logic ser);
    dif.dec1_valid = v; dif.dec1_rs1 = rs1; dif.dec1_rs2 = rs2; dif.dec1_rd = rd;
    dif.dec1_rdwe = we; dif.dec1_mem = mem; dif.dec1_serial = ser;
  endtask

  task automatic idle();
    set0(0, 0, 0, 0, 0, 0, 0);
    set1(0, 0, 0, 0, 0, 0, 0);
    wb0_en_i = 0; wb1_en_i = 0; retire_cnt_i = 0; flush_i = 0;
  endtask

  task automatic wb(input logic e0, input logic [4:0] a0, input logic e1, input logic [4:0] a1);
    wb0_en_i = e0; wb0_addr_i = a0; wb1_en_i = e1; wb1_addr_i = a1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic step();
`ifdef DU_ISSUE_PERF_EN
    if (cyc_acc_exp == 2) exp_dual++;
    if (cyc_acc_exp == 0 && dif.dec0_valid && !flush_i) exp_stall++;
`endif
    cyc_acc_exp = 0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    idle();
    dif.way0_ready = 1; dif.way1_ready = 1;
    repeat (2) @(posedge clk);
    mid();
    chk("rst_inflight", 32'(inflight_o), 0);
    chk("rst_pid1", 32'(dif.way1_pid), 1);
    reset_n = 1;
    step();
    mid();
    chk_acc("rst_accept", 0);
    chk("rst_valid0", 32'(dif.way0_valid), 0);
    chk("rst_pid0", 32'(dif.way0_pid), 0);
    step();

    // T1 independent pair x1<-x2, x3<-x4
    set0(1, 2, 0, 1, 1, 0, 0); set1(1, 4, 0, 3, 1, 0, 0);
    mid();
    chk_acc("t1_accept", 2);
    chk("t1_pid0", 32'(dif.way0_pid), 0);
    chk("t1_pid1", 32'(dif.way1_pid), 1);
    chk("t1_valid1", 32'(dif.way1_valid), 1);
    step();
    set0(1, 1, 0, 6, 1, 0, 0); set1(1, 3, 0, 14, 1, 0, 0);
    mid();
    chk("t1_pid0_next", 32'(dif.way0_pid), 2);
    chk("t1_pid1_next", 32'(dif.way1_pid), 3);
    chk("t1_inflight", 32'(inflight_o), 2);
    chk_acc("t1_busy_x1", 0);
    wb(1, 1, 0, 0);
    #1;
    chk_acc("t1_wb_bypass_x3_busy", 1);
    step();
    idle();

    // T3 in-flight limit (inflight=3)
    set0(1, 10, 0, 11, 1, 0, 0); set1(1, 12, 0, 13, 1, 0, 0);
    mid();
    chk_acc("t3_accept_one", 1);
    chk("t3_pid1_wrap", 32'(dif.way1_pid), 0);
    step();
    set0(1, 12, 0, 13, 1, 0, 0); set1(0, 0, 0, 0, 0, 0, 0);
    mid();
    chk("t3_inflight4", 32'(inflight_o), 4);
    chk_acc("t3_full", 0);
    retire_cnt_i = 1;
    step();
    retire_cnt_i = 0;
    mid();
    chk_acc("t3_after_retire", 1);
    chk("t3_pid0", 32'(dif.way0_pid), 0);
    step();
    idle(); retire_cnt_i = 2; wb(1, 3, 1, 6);
    step();
    retire_cnt_i = 2; wb(1, 11, 1, 13);
    step();
    idle();
    mid();
    chk("t3_drained", 32'(inflight_o), 0);
    step();

    // T2 dec1 depends on dec0 rd
    set0(1, 0, 0, 5, 1, 0, 0); set1(1, 5, 0, 7, 1, 0, 0);
    mid();
    chk_acc("t2_dep_accept", 1);
    chk("t2_valid1", 32'(dif.way1_valid), 0);
    chk("t2_pid0", 32'(dif.way0_pid), 1);
    step();
    set0(1, 5, 0, 7, 1, 0, 0); set1(0, 0, 0, 0, 0, 0, 0);
    wb(1, 5, 0, 0); dif.way0_ready = 0;
    mid();
    chk_acc("t2_wb_cycle", 0);
    step();
    wb(0, 0, 0, 0); dif.way0_ready = 1;
    mid();
    chk_acc("t2_reissue", 1);
    chk("t2_pid0_b", 32'(dif.way0_pid), 2);
    step();
    // two memory ops: single LSU
    set0(1, 0, 0, 0, 0, 1, 0); set1(1, 0, 0, 0, 0, 1, 0);
    mid();
    chk_acc("t2_two_mem", 1);
    step();
    idle(); retire_cnt_i = 2; wb(1, 7, 0, 0);
    step();
    idle(); retire_cnt_i = 1;
    step();
    idle();

    // T4 serialising instruction with inflight=2
    set0(1, 0, 0, 0, 0, 0, 0); set1(1, 0, 0, 0, 0, 0, 0);
    mid();
    chk("t4_inflight0", 32'(inflight_o), 0);
    chk_acc("t4_pair", 2);
    chk("t4_pid0", 32'(dif.way0_pid), 0);
    step();
    set0(1, 0, 0, 0, 0, 0, 1); set1(0, 0, 0, 0, 0, 0, 0);
    mid();
    chk_acc("t4_serial_blocked", 0);
    step();
    retire_cnt_i = 2;
    mid();
    chk_acc("t4_drain", 0);
    step();
    retire_cnt_i = 0;
    mid();
    chk_acc("t4_serial_issue", 1);
    chk("t4_serial_pid", 32'(dif.way0_pid), 2);
    step();
    set0(1, 0, 0, 0, 0, 0, 0); set1(1, 0, 0, 0, 0, 0, 0); retire_cnt_i = 1;
    mid();
    chk_acc("t4_serial_hold", 0);
    step();
    retire_cnt_i = 0;
    mid();
    chk_acc("t4_serial_empty", 0);
    step();
    mid();
    chk_acc("t4_back_run", 2);
    chk("t4_pid1", 32'(dif.way1_pid), 0);
    step();
    idle(); retire_cnt_i = 2;
    step();
    idle();

    // T5 flush with busy x7 and inflight=3
    set0(1, 0, 0, 7, 1, 0, 0); set1(1, 0, 0, 8, 1, 0, 0);
    mid();
    chk_acc("t5_pair", 2);
    step();
    set0(1, 0, 0, 9, 1, 0, 0); set1(0, 0, 0, 0, 0, 0, 0);
    mid();
    chk_acc("t5_third", 1);
    step();
    set0(1, 7, 0, 10, 1, 0, 0); set1(1, 8, 0, 11, 1, 0, 0); flush_i = 1;
    mid();
    chk("t5_inflight3", 32'(inflight_o), 3);
    chk_acc("t5_flush_accept", 0);
    chk("t5_flush_valid0", 32'(dif.way0_valid), 0);
    step();
    flush_i = 0;
    mid();
    chk("t5_inflight_cleared", 32'(inflight_o), 0);
    chk_acc("t5_busy_cleared", 2);
    chk("t5_pid_continues", 32'(dif.way0_pid), 0);
    step();
    idle(); retire_cnt_i = 2; wb(1, 10, 1, 11);
    step();
    idle();

    // T6 set beats same-cycle clear
    set0(1, 0, 0, 9, 1, 0, 0); wb(1, 9, 0, 0);
    mid();
    chk_acc("t6_issue", 1);
    step();
    set0(1, 9, 0, 12, 1, 0, 0); wb(0, 0, 0, 0);
    mid();
    chk_acc("t6_x9_busy", 0);
    step();
    idle(); retire_cnt_i = 1; wb(1, 9, 0, 0);
    step();
    idle();
    mid();
    chk("t6_final_inflight", 32'(inflight_o), 0);
`ifdef DU_ISSUE_PERF_EN
    chk("perf_stall", stall_cnt_o, 32'(exp_stall));
    chk("perf_dual", dual_cnt_o, 32'(exp_dual));
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
